// File: rtl/pc_predict_unit.sv
// Fetch PC generator with a direct-mapped BTB, EX-stage branch resolution and a
// RUN/HALT control FSM. Mispredicts redirect the PC and raise a one-cycle flush pulse.
module pc_predict_unit #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter bit              RVC_EN      = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [1:0]      inst_lo,
    input  logic            ex_valid,
    input  logic [1:0]      ex_type,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_rvc,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_imm,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    input  logic            sys_halt,
    input  logic            resume,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic            redirect,
    output logic            halted
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 1;

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e            state_q;
    logic              redirect_q;
    logic              halted_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pc_d;

    logic [BTB_ENTRIES-1:0] btb_valid_q;
    logic [TAG_W-1:0]       btb_tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_target_q [BTB_ENTRIES];
    logic [1:0]             btb_ctr_q    [BTB_ENTRIES];

    // Fetch-side lookup
    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic [XLEN-1:0]  seq_step;

    assign fetch_idx  = pc_q[IDX_W:1];
    assign fetch_tag  = pc_q[XLEN-1:IDX_W+1];
    assign pred_taken = btb_valid_q[fetch_idx] & (btb_tag_q[fetch_idx] == fetch_tag)
                        & btb_ctr_q[fetch_idx][1];
    assign seq_step   = (RVC_EN && (inst_lo != 2'b11)) ? XLEN'(2) : XLEN'(4);

    // EX-side resolution
    logic             ex_active;
    logic             br_cond;
    logic             actual_taken;
    logic [XLEN-1:0]  actual_target;
    logic [XLEN-1:0]  fall_through;
    logic [XLEN-1:0]  redirect_pc;
    logic             mispredict;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             run;

    assign ex_active = ex_valid & (ex_type != 2'b00);
    assign ex_idx    = ex_pc[IDX_W:1];
    assign ex_tag    = ex_pc[XLEN-1:IDX_W+1];
    assign ex_hit    = btb_valid_q[ex_idx] & (btb_tag_q[ex_idx] == ex_tag);
    assign run       = (state_q == StRun);

    always_comb begin
        br_cond = 1'b0;
        unique case (ex_funct3)
            3'b000:  br_cond = (ex_rs1 == ex_rs2);
            3'b001:  br_cond = (ex_rs1 != ex_rs2);
            3'b100:  br_cond = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  br_cond = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  br_cond = (ex_rs1 <  ex_rs2);
            3'b111:  br_cond = (ex_rs1 >= ex_rs2);
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        actual_taken  = 1'b0;
        actual_target = ex_pc + ex_imm;
        unique case (ex_type)
            2'b01:   actual_taken = br_cond;
            2'b10:   actual_taken = 1'b1;
            2'b11: begin
                actual_taken  = 1'b1;
                actual_target = (ex_rs1 + ex_imm) & ~XLEN'(1);
            end
            default: actual_taken = 1'b0;
        endcase
    end

    assign fall_through = ex_pc + (ex_rvc ? XLEN'(2) : XLEN'(4));
    assign redirect_pc  = actual_taken ? actual_target : fall_through;
    assign mispredict   = ex_active & ((actual_taken != ex_pred_taken) |
                          (actual_taken & (actual_target != ex_pred_target)));

    // Next-PC priority: redirect, halt hold (released by resume), stall, prediction, step
    always_comb begin
        pc_d = pc_q + seq_step;
        if (run && mispredict) begin
            pc_d = redirect_pc;
        end else if (!run && !resume) begin
            pc_d = pc_q;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = btb_target_q[fetch_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StRun;
            redirect_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                StRun: begin
                    redirect_q <= mispredict;
                    if (sys_halt) begin
                        state_q  <= StHalt;
                        halted_q <= 1'b1;
                    end
                end
                StHalt: begin
                    redirect_q <= 1'b0;
                    if (resume) begin
                        state_q  <= StRun;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StRun;
                    redirect_q <= 1'b0;
                    halted_q   <= 1'b0;
                end
            endcase
        end
    end

    // Reads see the pre-edge contents, so a same-index update is never bypassed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btb_valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
                btb_ctr_q[i]    <= 2'd1;
            end
        end else if (run && ex_active) begin
            if (ex_hit) begin
                if (actual_taken && (btb_ctr_q[ex_idx] != 2'd3)) begin
                    btb_ctr_q[ex_idx] <= btb_ctr_q[ex_idx] + 2'd1;
                end else if (!actual_taken && (btb_ctr_q[ex_idx] != 2'd0)) begin
                    btb_ctr_q[ex_idx] <= btb_ctr_q[ex_idx] - 2'd1;
                end
            end else if (actual_taken) begin
                btb_valid_q[ex_idx]  <= 1'b1;
                btb_tag_q[ex_idx]    <= ex_tag;
                btb_target_q[ex_idx] <= actual_target;
                btb_ctr_q[ex_idx]    <= 2'd2;
            end
        end
    end

    assign pc       = pc_q;
    assign redirect = redirect_q;
    assign halted   = halted_q;

endmodule

// File: doc/pc_predict_unit.md
PC_PREDICT_UNIT -- requirements
Module: pc_predict_unit

Interface
REQ-001 Parameter XLEN, default 32, address/data width.
REQ-002 Parameter BTB_ENTRIES, default 16, direct-mapped branch target buffer (BTB) depth, power of two, minimum 2.
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 Parameter RVC_EN, default 1, enables 2-byte instruction stepping.
REQ-005 clk  in  1  sole clock, rising-edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 stall  in  1  hold fetch PC (hazard).
REQ-008 inst_lo  in  2  bits [1:0] of the instruction fetched at pc.
REQ-009 ex_valid  in  1  resolving control-flow instruction present in EX.
REQ-010 ex_type  in  2  00 none, 01 branch, 10 JAL, 11 JALR.
REQ-011 ex_funct3  in  3  branch condition code.
REQ-012 ex_pc  in  XLEN  PC of the EX instruction.
REQ-013 ex_rvc  in  1  EX instruction is 2 bytes.
REQ-014 ex_rs1, ex_rs2  in  XLEN  operands.
REQ-015 ex_imm  in  XLEN  sign-extended immediate.
REQ-016 ex_pred_taken, ex_pred_target  in  1/XLEN  prediction carried down with the EX instruction.
REQ-017 sys_halt  in  1  ECALL/EBREAK retiring.
REQ-018 resume  in  1  external release from halt.
REQ-019 pc  out  XLEN  registered fetch PC.
REQ-020 pred_taken  out  1  combinational BTB hit-and-taken for the current pc.
REQ-021 redirect  out  1  registered one-cycle flush pulse on mispredict.
REQ-022 halted  out  1  FSM is in HALT.

Function
REQ-023 Sequential step = 4, or 2 when RVC_EN=1 and inst_lo != 2'b11.
REQ-024 BTB index = pc[log2(BTB_ENTRIES):1]; tag = the remaining upper bits; each entry holds valid, tag, target, and a 2-bit saturating counter.
REQ-025 pred_taken = valid & tag match & counter[1]; when pred_taken=1, next pc = BTB target.
REQ-026 Actual outcome: branch compares per funct3 (000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned geu); other funct3 values resolve not-taken; JAL and JALR are always taken.
REQ-027 Target: ex_pc+ex_imm for branch and JAL; (ex_rs1+ex_imm) & ~1 for JALR; fall-through = ex_pc + (ex_rvc ? 2 : 4); all sums are modulo 2^XLEN.
REQ-028 Mispredict = ex_valid & ex_type!=0 & (actual_taken != ex_pred_taken, or both taken with target != ex_pred_target).
REQ-029 On mispredict, the next pc = actual target if taken, else fall-through, and redirect=1 for exactly one cycle.
REQ-030 BTB update on ex_valid & ex_type!=0: on a tag hit, counter increments on taken and decrements on not-taken, saturating at 3 and 0.
REQ-031 On a BTB miss with a taken outcome, the entry is allocated: valid=1, tag and target written, counter=2; a BTB miss with a not-taken outcome writes nothing.
REQ-032 Next-pc priority: redirect > HALT hold > stall hold > prediction > sequential; redirect overrides stall.
REQ-033 FSM RUN->HALT on sys_halt; HALT->RUN on resume; sys_halt and resume asserted together in RUN goes to HALT.
REQ-034 In HALT, pc is held, redirect=0, and BTB updates are suppressed; sys_halt and a mispredict in the same cycle load the redirect target, then enter HALT.
REQ-035 A BTB read and a write to the same index in the same cycle returns the old entry (no bypass).

Reset
REQ-036 rst=0 asynchronously sets pc=RESET_PC, all BTB valid=0 and counters=1, FSM=RUN, redirect=0, halted=0; it aborts any update in progress; the first fetch is RESET_PC after rst deasserts.

Verification
REQ-037 Reset, stall=0, inst_lo=11, no EX activity -> pc 0,4,8,12; with inst_lo=01 -> pc steps by 2.
REQ-038 BEQ at ex_pc=0x20, rs1=rs2=5, imm=0x40, pred_taken=0 -> redirect pulse, pc=0x60, BTB entry allocated with counter=2; next fetch at 0x20 -> pred_taken=1, pc=0x60.
REQ-039 BLTU rs1=0xFFFFFFFF, rs2=1 -> not-taken, while BLT on the same operands -> taken; a predicted-taken BLTU redirects to ex_pc+4, and the counter drops from 2 to 1.
REQ-040 JALR rs1=0x103, imm=0 -> target 0x102 with redirect; stall=1 in the same cycle -> redirect still applied.
REQ-041 sys_halt in RUN -> halted=1, pc frozen for 10 cycles ignoring mispredicts; resume -> pc advances by 4 on the next edge.
REQ-042 rst asserted mid-stall while in HALT with BTB populated -> pc=RESET_PC, halted=0, and the first lookup misses (pred_taken=0).
